du_issue_scheduler: RTL and testbench

//  In-order dual-issue scheduler between the way0/way1 decoders and EX.

---
 rtl/du_issue_scheduler_pkg.sv | 32 +++
 rtl/du_issue_scheduler_scoreboard.sv | 46 ++++
 rtl/du_issue_scheduler.sv | 164 ++++++++++++++++
 tb/tb_du_issue_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/du_issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: FSM states, decoded-slot payload, helpers.
package b8_issue_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SLOT_PID_W = 8;
  localparam int unsigned NUM_LKP    = 4;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    PAIR    = 1'b0,
    W1_HELD = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rs1_en;
    logic                  rs2_en;
    logic                  rd_we;
    logic                  long_lat;
    logic [SLOT_PID_W-1:0] pid;
  } slot_t;

  // A slot produces a visible architectural result in a non-zero rd.
  function automatic logic writes_rd(input slot_t s);
    return (s.rd_we || s.long_lat) && (s.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/du_issue_scheduler_scoreboard.sv
// Busy-register scoreboard for long-latency destinations; set wins over clear.
module issue_scoreboard
  import b8_issue_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_set0_en,
  input  logic [REG_ADDR_W-1:0]                i_set0_addr,
  input  logic                                 i_set1_en,
  input  logic [REG_ADDR_W-1:0]                i_set1_addr,
  input  logic                                 i_clr_en,
  input  logic [REG_ADDR_W-1:0]                i_clr_addr,
  input  logic [NUM_LKP-1:0][REG_ADDR_W-1:0]   i_lkp_addr,
  output logic [NUM_LKP-1:0]                   o_lkp_busy,
  output logic [NUM_REGS-1:0]                  o_busy
);

  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_sb_nxt;

  // Clear applied first so a same-cycle set of the same register survives.
  always_comb begin
    w_sb_nxt = r_sb;
    if (i_clr_en)  w_sb_nxt[i_clr_addr]  = 1'b0;
    if (i_set0_en) w_sb_nxt[i_set0_addr] = 1'b1;
    if (i_set1_en) w_sb_nxt[i_set1_addr] = 1'b1;
    w_sb_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_nxt;
  end

  always_comb begin
    o_lkp_busy = '0;
    for (int unsigned i = 0; i < NUM_LKP; i++) begin
      o_lkp_busy[i] = r_sb[i_lkp_addr[i]];
    end
  end

  assign o_busy = r_sb;

endmodule

// File: rtl/du_issue_scheduler.sv
// In-order dual-issue scheduler: hazard checks, held-way1 FSM, pID muxing, stall counter.
module du_issue_scheduler
  import b8_issue_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned PID_W    = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  way0_valid_i,
  input  logic [PID_W-1:0]      way0_pID_i,
  input  logic [4:0]            way0_rs1Addr_i,
  input  logic [4:0]            way0_rs2Addr_i,
  input  logic                  way0_rs1ReadEnable_i,
  input  logic                  way0_rs2ReadEnable_i,
  input  logic [4:0]            way0_rdAddr_i,
  input  logic                  way0_rdWriteEnable_i,
  input  logic                  way0_longLat_i,
  input  logic                  way1_valid_i,
  input  logic [PID_W-1:0]      way1_pID_i,
  input  logic [4:0]            way1_rs1Addr_i,
  input  logic [4:0]            way1_rs2Addr_i,
  input  logic                  way1_rs1ReadEnable_i,
  input  logic                  way1_rs2ReadEnable_i,
  input  logic [4:0]            way1_rdAddr_i,
  input  logic                  way1_rdWriteEnable_i,
  input  logic                  way1_longLat_i,
  input  logic                  exReady_i,
  input  logic                  wbValid_i,
  input  logic [4:0]            wbRdAddr_i,
  input  logic                  flush_i,
  output logic                  issue0_o,
  output logic                  issue1_o,
  output logic [PID_W-1:0]      issue0_pID_o,
  output logic [PID_W-1:0]      issue1_pID_o,
  output logic                  issueSel0_o,
  output logic                  ready_o,
  output logic [CNT_W-1:0]      stallCnt_o
);

  slot_t                              w_s0;
  slot_t                              w_s1;
  slot_t                              w_port0;
  issue_state_e                       r_state;
  issue_state_e                       w_state_nxt;
  logic [NUM_LKP-1:0][REG_ADDR_W-1:0] w_lkp_addr;
  logic [NUM_LKP-1:0]                 w_lkp_busy;
  logic [NUM_REGS-1:0]                w_busy;
  logic                               w_hz0;
  logic                               w_hz1;
  logic                               w_intra;
  logic                               w_issue0;
  logic                               w_issue1;
  logic                               w_ready;
  logic                               w_stall;
  logic                               w_set0_en;
  logic                               w_set1_en;
  logic [CNT_W-1:0]                   r_stall_cnt;

  always_comb begin
    w_s0          = '0;
    w_s0.valid    = way0_valid_i;
    w_s0.rs1      = way0_rs1Addr_i;
    w_s0.rs2      = way0_rs2Addr_i;
    w_s0.rd       = way0_rdAddr_i;
    w_s0.rs1_en   = way0_rs1ReadEnable_i;
    w_s0.rs2_en   = way0_rs2ReadEnable_i;
    w_s0.rd_we    = way0_rdWriteEnable_i;
    w_s0.long_lat = way0_longLat_i;
    w_s0.pid      = SLOT_PID_W'(way0_pID_i);
    w_s1          = '0;
    w_s1.valid    = way1_valid_i;
    w_s1.rs1      = way1_rs1Addr_i;
    w_s1.rs2      = way1_rs2Addr_i;
    w_s1.rd       = way1_rdAddr_i;
    w_s1.rs1_en   = way1_rs1ReadEnable_i;
    w_s1.rs2_en   = way1_rs2ReadEnable_i;
    w_s1.rd_we    = way1_rdWriteEnable_i;
    w_s1.long_lat = way1_longLat_i;
    w_s1.pid      = SLOT_PID_W'(way1_pID_i);
  end

  assign w_port0 = (r_state == W1_HELD) ? w_s1 : w_s0;

  assign w_lkp_addr[0] = w_s0.rs1;
  assign w_lkp_addr[1] = w_s0.rs2;
  assign w_lkp_addr[2] = w_s1.rs1;
  assign w_lkp_addr[3] = w_s1.rs2;

  // Destination check covers WAW against an outstanding long-latency write.
  assign w_hz0 = (w_s0.rs1_en && w_lkp_busy[0]) || (w_s0.rs2_en && w_lkp_busy[1]) ||
                 ((w_s0.rd_we || w_s0.long_lat) && w_busy[w_s0.rd]);
  assign w_hz1 = (w_s1.rs1_en && w_lkp_busy[2]) || (w_s1.rs2_en && w_lkp_busy[3]) ||
                 ((w_s1.rd_we || w_s1.long_lat) && w_busy[w_s1.rd]);

  assign w_intra = writes_rd(w_s0) &&
                   ((w_s1.rs1_en && (w_s1.rs1 == w_s0.rd)) ||
                    (w_s1.rs2_en && (w_s1.rs2 == w_s0.rd)) ||
                    (w_s1.rd == w_s0.rd));

  // Issue decision and next state; flush and reset suppress all issue.
  always_comb begin
    w_issue0    = 1'b0;
    w_issue1    = 1'b0;
    w_ready     = 1'b0;
    w_state_nxt = r_state;
    if (rst) begin
      w_state_nxt = PAIR;
    end else if (flush_i) begin
      w_ready     = 1'b1;
      w_state_nxt = PAIR;
    end else if (r_state == PAIR) begin
      w_issue0 = w_s0.valid && exReady_i && !w_hz0;
      w_issue1 = w_issue0 && w_s1.valid && !w_hz1 && !w_intra &&
                 !(w_s0.long_lat && w_s1.long_lat);
      w_ready  = (w_issue0 && (w_issue1 || !w_s1.valid)) || !w_s0.valid;
      if (w_issue0 && w_s1.valid && !w_issue1) w_state_nxt = W1_HELD;
    end else begin
      w_issue0 = w_s1.valid && exReady_i && !w_hz1;
      w_ready  = w_issue0;
      if (w_issue0) w_state_nxt = PAIR;
    end
  end

  assign w_stall   = !rst && !flush_i && w_port0.valid && !w_issue0;
  assign w_set0_en = w_issue0 && w_port0.long_lat && (w_port0.rd != REG_ZERO);
  assign w_set1_en = w_issue1 && w_s1.long_lat && (w_s1.rd != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PAIR;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  issue_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_set0_en   (w_set0_en),
    .i_set0_addr (w_port0.rd),
    .i_set1_en   (w_set1_en),
    .i_set1_addr (w_s1.rd),
    .i_clr_en    (wbValid_i),
    .i_clr_addr  (wbRdAddr_i),
    .i_lkp_addr  (w_lkp_addr),
    .o_lkp_busy  (w_lkp_busy),
    .o_busy      (w_busy)
  );

  assign issue0_o     = w_issue0;
  assign issue1_o     = w_issue1;
  assign ready_o      = w_ready;
  assign issueSel0_o  = !rst && (r_state == W1_HELD);
  assign issue0_pID_o = rst ? '0 : PID_W'(w_port0.pid);
  assign issue1_pID_o = rst ? '0 : PID_W'(w_s1.pid);
  assign stallCnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_du_issue_scheduler.sv
// Directed + randomized bench for du_issue_scheduler against a behavioural issue model.
module tb_du_issue_scheduler;

  localparam int unsigned PID_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v[2];
  logic [PID_W-1:0] pid[2];
  logic [4:0] rs1[2];
  logic [4:0] rs2[2];
  logic [4:0] rd[2];
  logic e1[2];
  logic e2[2];
  logic we[2];
  logic ll[2];
  logic ex_rdy, wbv, flush;
  logic [4:0] wba;
  logic o_i0, o_i1, o_sel, o_rdy;
  logic [PID_W-1:0] o_p0, o_p1;
  logic [CNT_W-1:0] o_cnt;

  bit          m_held = 1'b0;
  logic [31:0] m_sb = '0;
  int          m_cnt = 0;
  bit          m_rdy_last = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  du_issue_scheduler #(.NUM_REGS(32), .PID_W(PID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .way0_valid_i(v[0]), .way0_pID_i(pid[0]),
    .way0_rs1Addr_i(rs1[0]), .way0_rs2Addr_i(rs2[0]),
    .way0_rs1ReadEnable_i(e1[0]), .way0_rs2ReadEnable_i(e2[0]),
    .way0_rdAddr_i(rd[0]), .way0_rdWriteEnable_i(we[0]), .way0_longLat_i(ll[0]),
    .way1_valid_i(v[1]), .way1_pID_i(pid[1]),
    .way1_rs1Addr_i(rs1[1]), .way1_rs2Addr_i(rs2[1]),
    .way1_rs1ReadEnable_i(e1[1]), .way1_rs2ReadEnable_i(e2[1]),
    .way1_rdAddr_i(rd[1]), .way1_rdWriteEnable_i(we[1]), .way1_longLat_i(ll[1]),
    .exReady_i(ex_rdy), .wbValid_i(wbv), .wbRdAddr_i(wba), .flush_i(flush),
    .issue0_o(o_i0), .issue1_o(o_i1), .issue0_pID_o(o_p0), .issue1_pID_o(o_p1),
    .issueSel0_o(o_sel), .ready_o(o_rdy), .stallCnt_o(o_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit hz(input int w);
    return (e1[w] && m_sb[rs1[w]]) || (e2[w] && m_sb[rs2[w]]) ||
           ((we[w] || ll[w]) && m_sb[rd[w]]);
  endfunction

  function automatic bit intra();
    if (!((we[0] || ll[0]) && rd[0] != 5'd0)) return 1'b0;
    return (e1[1] && rs1[1] == rd[0]) || (e2[1] && rs2[1] == rd[0]) || (rd[1] == rd[0]);
  endfunction

  // Reference model: evaluate issue rules, compare, then advance to next cycle.
  int          p;
  bit          x0, x1, xr;
  logic [31:0] nsb;
  always @(negedge clk) begin
    p = m_held ? 1 : 0;
    if (rst) begin
      x0 = 1'b0; x1 = 1'b0; xr = 1'b0;
    end else if (flush) begin
      x0 = 1'b0; x1 = 1'b0; xr = 1'b1;
    end else if (!m_held) begin
      x0 = v[0] && ex_rdy && !hz(0);
      x1 = x0 && v[1] && !hz(1) && !intra() && !(ll[0] && ll[1]);
      xr = (x0 && (x1 || !v[1])) || !v[0];
    end else begin
      x0 = v[1] && ex_rdy && !hz(1);
      x1 = 1'b0;
      xr = x0;
    end
    chk("issue0", 32'(o_i0), 32'(x0));
    chk("issue1", 32'(o_i1), 32'(x1));
    chk("ready", 32'(o_rdy), 32'(xr));
    chk("stallCnt", 32'(o_cnt), 32'(m_cnt));
    chk("scoreboard", dut.u_sb.o_busy, m_sb);
    if (x0) begin
      chk("issueSel0", 32'(o_sel), 32'(m_held));
      chk("issue0_pID", 32'(o_p0), 32'(pid[p]));
    end
    if (x1) chk("issue1_pID", 32'(o_p1), 32'(pid[1]));
    m_rdy_last = xr;
    if (rst) begin
      m_held = 1'b0; m_sb = '0; m_cnt = 0;
    end else begin
      nsb = m_sb;
      if (wbv) nsb[wba] = 1'b0;
      if (x0 && ll[p] && rd[p] != 5'd0) nsb[rd[p]] = 1'b1;
      if (x1 && ll[1] && rd[1] != 5'd0) nsb[rd[1]] = 1'b1;
      m_sb = nsb;
      if (!flush && v[p] && !x0 && m_cnt < int'(CNT_MAX)) m_cnt++;
      if (flush)        m_held = 1'b0;
      else if (!m_held) m_held = x0 && v[1] && !x1;
      else              m_held = !x0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int w, input bit vv, input int a1, input bit en1,
                          input int a2, input bit en2, input int ad, input bit wen,
                          input bit l, input int pd);
    v[w] = vv; rs1[w] = 5'(a1); e1[w] = en1; rs2[w] = 5'(a2); e2[w] = en2;
    rd[w] = 5'(ad); we[w] = wen; ll[w] = l; pid[w] = PID_W'(pd);
  endtask

  task automatic rand_slot(input int w);
    set_slot(w, $urandom_range(3) != 0, int'($urandom_range(7)), 1'($urandom_range(1)),
             int'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(7)),
             1'($urandom_range(1)), $urandom_range(3) == 0, int'($urandom_range(3)));
  endtask

  initial begin
    for (int w = 0; w < 2; w++) set_slot(w, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    ex_rdy = 1'b1; wbv = 1'b0; wba = '0; flush = 1'b0;
    v[0] = 1'b1;
    tick(); #2;
    chk("rst_issue0", 32'(o_i0), 32'd0);
    chk("rst_ready", 32'(o_rdy), 32'd0);
    tick(); rst = 1'b0; v[0] = 1'b0; #2;
    chk("rst_stallCnt", 32'(o_cnt), 32'd0);

    // Independent pair
    set_slot(0, 1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1);
    set_slot(1, 1'b1, 7, 1'b1, 8, 1'b1, 6, 1'b1, 1'b0, 2);
    #2;
    chk("t1_issue0", 32'(o_i0), 32'd1);
    chk("t1_issue1", 32'(o_i1), 32'd1);
    chk("t1_ready", 32'(o_rdy), 32'd1);
    chk("t1_pID1", 32'(o_p1), 32'd2);
    tick(); v[0] = 1'b0; v[1] = 1'b0;

    // Intra-pair RAW holds way1 for one cycle
    tick();
    set_slot(0, 1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 0);
    set_slot(1, 1'b1, 5, 1'b1, 2, 1'b1, 6, 1'b1, 1'b0, 3);
    #2;
    chk("t2_issue0", 32'(o_i0), 32'd1);
    chk("t2_issue1", 32'(o_i1), 32'd0);
    chk("t2_ready0", 32'(o_rdy), 32'd0);
    tick(); #2;
    chk("t2_held_issue0", 32'(o_i0), 32'd1);
    chk("t2_held_sel0", 32'(o_sel), 32'd1);
    chk("t2_held_pID0", 32'(o_p0), 32'd3);
    chk("t2_held_ready", 32'(o_rdy), 32'd1);
    tick(); v[0] = 1'b0; v[1] = 1'b0;

    // Load-use stall released the cycle after writeback
    set_slot(0, 1'b1, 2, 1'b1, 0, 1'b0, 9, 1'b1, 1'b1, 1);
    #2;
    chk("t3_ld_issue0", 32'(o_i0), 32'd1);
    tick();
    set_slot(0, 1'b1, 9, 1'b1, 0, 1'b0, 10, 1'b1, 1'b0, 2);
    #2; chk("t3_stall_a", 32'(o_i0), 32'd0);
    tick(); #2; chk("t3_stall_b", 32'(o_i0), 32'd0);
    tick(); #2; chk("t3_stall_c", 32'(o_i0), 32'd0);
    chk("t3_cnt2", 32'(o_cnt), 32'd2);
    tick(); wbv = 1'b1; wba = 5'd9; #2;
    chk("t3_wb_cycle", 32'(o_i0), 32'd0);
    chk("t3_cnt3", 32'(o_cnt), 32'd3);
    tick(); wbv = 1'b0; #2;
    chk("t3_release", 32'(o_i0), 32'd1);
    chk("t3_cnt4", 32'(o_cnt), 32'd4);
    tick(); v[0] = 1'b0;

    // Two long-latency ops split across cycles
    set_slot(0, 1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b1, 0);
    set_slot(1, 1'b1, 2, 1'b1, 0, 1'b0, 4, 1'b1, 1'b1, 1);
    #2;
    chk("t4_issue0", 32'(o_i0), 32'd1);
    chk("t4_issue1", 32'(o_i1), 32'd0);
    tick(); #2;
    chk("t4_sb3", 32'(dut.u_sb.o_busy[3]), 32'd1);
    chk("t4_held_issue0", 32'(o_i0), 32'd1);
    chk("t4_held_pID0", 32'(o_p0), 32'd1);
    tick(); v[0] = 1'b0; v[1] = 1'b0; #2;
    chk("t4_sb4", 32'(dut.u_sb.o_busy[4]), 32'd1);

    // Same-cycle clear and set of x3: set wins
    wbv = 1'b1; wba = 5'd3;
    tick();
    set_slot(0, 1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b1, 2);
    #2; chk("t5_issue0", 32'(o_i0), 32'd1);
    tick(); wbv = 1'b0; v[0] = 1'b0; #2;
    chk("t5_sb3", 32'(dut.u_sb.o_busy[3]), 32'd1);
    wbv = 1'b1; wba = 5'd3;
    tick(); wbv = 1'b0;

    // Flush while way1 is held keeps the scoreboard
    set_slot(0, 1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 0);
    set_slot(1, 1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0, 1);
    tick(); flush = 1'b1; #2;
    chk("t6_flush_issue0", 32'(o_i0), 32'd0);
    chk("t6_flush_issue1", 32'(o_i1), 32'd0);
    chk("t6_flush_ready", 32'(o_rdy), 32'd1);
    tick(); flush = 1'b0;
    set_slot(0, 1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0, 2);
    v[1] = 1'b0; #2;
    chk("t6_pair_issue0", 32'(o_i0), 32'd1);
    chk("t6_pair_sel0", 32'(o_sel), 32'd0);
    chk("t6_sb4", 32'(dut.u_sb.o_busy[4]), 32'd1);
    tick();
    set_slot(0, 1'b1, 4, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0, 3);
    repeat (14) tick();
    #2;
    chk("t6_cnt_sat", 32'(o_cnt), CNT_MAX);
    wbv = 1'b1; wba = 5'd4;
    tick(); wbv = 1'b0; v[0] = 1'b0;
    tick();

    // Randomized traffic with the decoder pair held until accepted
    for (int c = 0; c < 2500; c++) begin
      tick();
      rst    = ($urandom_range(63) == 0);
      flush  = ($urandom_range(15) == 0);
      ex_rdy = ($urandom_range(3) != 0);
      wbv    = ($urandom_range(2) == 0);
      wba    = 5'($urandom_range(7));
      if (m_rdy_last) begin
        rand_slot(0);
        rand_slot(1);
      end
    end
    tick(); rst = 1'b0; flush = 1'b0; wbv = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
